// File: rtl/spi_bridge.sv
// SPI mode-0 slave bridge: oversamples sclk/cs_n/mosi in the clk domain, delivers
// received bytes to the instruction decoder and shifts decoder bytes out on miso.
module spi_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       byte_sync,
  output logic [7:0] data_in,
  input  logic [7:0] data_out
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t              state, state_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0]   rx, rx_n, tx, tx_n, data_in_n;
  logic                byte_sync_n, miso_n, reload, reload_n;

  // Synchronizer chains plus one edge-detect flop on sclk and cs_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      reload    <= 1'b0;
      data_in   <= '0;
      byte_sync <= 1'b0;
      miso      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx        <= rx_n;
      tx        <= tx_n;
      reload    <= reload_n;
      data_in   <= data_in_n;
      byte_sync <= byte_sync_n;
      miso      <= miso_n;
    end
  end

  // Next-state: a cs_n rise pre-empts any sclk edge seen in the same cycle
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    rx_n        = rx;
    tx_n        = tx;
    reload_n    = reload;
    data_in_n   = data_in;
    byte_sync_n = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n   = ACTIVE;
          bit_cnt_n = '0;
          tx_n      = data_out;
          reload_n  = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
          reload_n  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_n      = {rx[BYTE_W-2:0], mosi_s};
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              data_in_n   = {rx[BYTE_W-2:0], mosi_s};
              byte_sync_n = 1'b1;
              reload_n    = 1'b1;
            end
          end
          if (sclk_fall) begin
            if (reload) begin
              tx_n     = data_out;
              reload_n = 1'b0;
            end else begin
              tx_n = {tx[BYTE_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    miso_n = (state_n == ACTIVE) ? tx_n[BYTE_W-1] : 1'b0;
  end

endmodule

// File: tb/tb_spi_bridge.sv
// Bench for spi_bridge: bit-banged SPI master at sclk = clk/10 with a byte scoreboard.
module tb_spi_bridge;

  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out = 8'h00;

  spi_bridge #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .byte_sync(byte_sync), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mosi_byte;
    logic [7:0] dout;
    logic [7:0] exp_data_in;
    logic [7:0] exp_miso;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int last_bs_cyc = 0;
  int last_rise_cyc = 0;
  int idle_bad = 0;
  bit idle_chk = 1'b0;
  bit prev_bs = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] dout_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clk cycle; byte_sync pulses are scored against the expected-byte queue here
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (idle_chk && miso !== 1'b0) idle_bad++;
    if (byte_sync === 1'b1) begin
      pulses++;
      last_bs_cyc = cyc;
      if (prev_bs) chk("byte_sync_width", 32'(byte_sync), 32'd0);
      if (exp_q.size() == 0) chk("byte_sync_unexpected", 32'(byte_sync), 32'd0);
      else chk("data_in_scoreboard", 32'(data_in), 32'(exp_q.pop_front()));
      if (dout_q.size() != 0) data_out = dout_q.pop_front();
    end
    prev_bs = (byte_sync === 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Mode 0: drive mosi while sclk low, sample miso just before the rising edge
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      ticks(5);
      mi = {mi[6:0], miso};
      sclk = 1'b1;
      last_rise_cyc = cyc;
      ticks(5);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    ticks(10);
  endtask

  task automatic frame_end();
    ticks(5);
    cs_n = 1'b1;
    ticks(10);
  endtask

  vec_t vecs[4];

  initial begin
    logic [7:0] m1, m2;
    int p0;

    vecs[0] = '{mosi_byte: 8'hA5, dout: 8'hC3, exp_data_in: 8'hA5, exp_miso: 8'hC3};
    vecs[1] = '{mosi_byte: 8'h00, dout: 8'hFF, exp_data_in: 8'h00, exp_miso: 8'hFF};
    vecs[2] = '{mosi_byte: 8'hFF, dout: 8'h01, exp_data_in: 8'hFF, exp_miso: 8'h01};
    vecs[3] = '{mosi_byte: 8'h96, dout: 8'h6B, exp_data_in: 8'h96, exp_miso: 8'h6B};

    // Reset values
    ticks(4);
    chk("reset_data_in", 32'(data_in), 32'h00);
    chk("reset_byte_sync", 32'(byte_sync), 32'd0);
    chk("reset_miso", 32'(miso), 32'd0);
    rst_n = 1'b1;
    ticks(5);

    // Single-byte frames from the vector table
    foreach (vecs[k]) begin
      data_out = vecs[k].dout;
      p0 = pulses;
      frame_start();
      exp_q.push_back(vecs[k].exp_data_in);
      spi_bits(vecs[k].mosi_byte, 8, m1);
      chk($sformatf("vec%0d_miso", k), 32'(m1), 32'(vecs[k].exp_miso));
      chk($sformatf("vec%0d_latency_ok", k),
          32'((last_bs_cyc > last_rise_cyc) &&
              (last_bs_cyc - last_rise_cyc <= int'(SYNC_STAGES) + 2)), 32'd1);
      frame_end();
      chk($sformatf("vec%0d_pulses", k), 32'(pulses - p0), 32'd1);
      chk($sformatf("vec%0d_data_in_hold", k), 32'(data_in), 32'(vecs[k].exp_data_in));
    end

    // Two-byte frame, decoder supplies 0x5A after the first byte_sync
    data_out = 8'hE7;
    dout_q.push_back(8'h5A);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h3C);
    p0 = pulses;
    frame_start();
    spi_bits(8'h81, 8, m1);
    spi_bits(8'h3C, 8, m2);
    frame_end();
    chk("two_byte_miso0", 32'(m1), 32'hE7);
    chk("two_byte_miso1", 32'(m2), 32'h5A);
    chk("two_byte_pulses", 32'(pulses - p0), 32'd2);
    chk("two_byte_data_in", 32'(data_in), 32'h3C);

    // Aborted byte after 5 bits of 0xFF
    p0 = pulses;
    frame_start();
    spi_bits(8'hFF, 5, m1);
    frame_end();
    chk("abort_pulses", 32'(pulses - p0), 32'd0);
    chk("abort_data_in", 32'(data_in), 32'h3C);
    exp_q.push_back(8'h12);
    frame_start();
    spi_bits(8'h12, 8, m1);
    frame_end();
    chk("after_abort_pulses", 32'(pulses - p0), 32'd1);
    chk("after_abort_data_in", 32'(data_in), 32'h12);

    // cs_n rise coincident with the 8th sclk rise: cs_n wins, no byte
    p0 = pulses;
    frame_start();
    spi_bits(8'hF0, 7, m1);
    mosi = 1'b1;
    ticks(5);
    sclk = 1'b1;
    cs_n = 1'b1;
    ticks(10);
    sclk = 1'b0;
    ticks(5);
    chk("simul_edge_pulses", 32'(pulses - p0), 32'd0);
    chk("simul_edge_data_in", 32'(data_in), 32'h12);

    // Idle noise on sclk/mosi with cs_n high
    p0 = pulses;
    idle_bad = 0;
    idle_chk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      ticks(3);
    end
    sclk = 1'b0;
    ticks(5);
    idle_chk = 1'b0;
    chk("idle_miso_nonzero_cycles", 32'(idle_bad), 32'd0);
    chk("idle_pulses", 32'(pulses - p0), 32'd0);

    // Reset after bit 4 of a byte, then a fresh 0x7E frame
    data_out = 8'hFF;
    frame_start();
    spi_bits(8'hB7, 4, m1);
    rst_n = 1'b0;
    ticks(3);
    chk("midreset_data_in", 32'(data_in), 32'h00);
    chk("midreset_byte_sync", 32'(byte_sync), 32'd0);
    chk("midreset_miso", 32'(miso), 32'd0);
    cs_n = 1'b1;
    ticks(3);
    rst_n = 1'b1;
    ticks(10);
    p0 = pulses;
    exp_q.push_back(8'h7E);
    frame_start();
    spi_bits(8'h7E, 8, m1);
    frame_end();
    chk("post_reset_pulses", 32'(pulses - p0), 32'd1);
    chk("post_reset_data_in", 32'(data_in), 32'h7E);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
